// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and defaults for the AES-128 round controller.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package aes_pkg;

  localparam int NR_DEFAULT  = 10;
  localparam int RCW_DEFAULT = 4;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

endpackage : aes_pkg

`default_nettype wire

// File: rtl/aes_round_ctrl_if.sv
// ============================================================================
// Module      : aes_round_ctrl_if
// Description : Block handshake and round-datapath signals of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface aes_round_ctrl_if
  import aes_pkg::*;
#(
  parameter int RCW = RCW_DEFAULT
);

  logic           in_valid;
  logic           in_ready;
  aes_block_t     in_data;
  aes_block_t     in_key;
  logic [RCW-1:0] rnd_rc;
  aes_block_t     rnd_data;
  aes_block_t     rnd_key;
  logic           rnd_last;
  aes_block_t     rnd_out;
  aes_block_t     rnd_keyout;
  logic           out_valid;
  logic           out_ready;
  aes_block_t     out_data;

  // Controller side
  modport slave (
    input  in_valid, in_data, in_key, rnd_out, rnd_keyout, out_ready,
    output in_ready, rnd_rc, rnd_data, rnd_key, rnd_last, out_valid, out_data
  );

  // Producer / datapath / consumer side
  modport master (
    output in_valid, in_data, in_key, rnd_out, rnd_keyout, out_ready,
    input  in_ready, rnd_rc, rnd_data, rnd_key, rnd_last, out_valid, out_data
  );

endinterface : aes_round_ctrl_if

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module      : aes_round_ctrl
// Description : Iterative AES-128 round sequencer; the round datapath sits
//               outside and is driven through rnd_* signals.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR  = NR_DEFAULT,
  parameter int RCW = RCW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_round_ctrl_if.slave        bus
);

  localparam int CW = $clog2(NR + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(NR);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  aes_state_e   r_fsm;
  aes_state_e   w_fsm_nxt;
  aes_block_t   r_blk;
  aes_block_t   r_key;
  logic [CW-1:0] r_cnt;

  logic w_load;
  logic w_step;
  logic w_cnt_last;

  assign w_load     = (r_fsm == ST_IDLE) && bus.in_valid;
  assign w_step     = (r_fsm == ST_ROUND);
  assign w_cnt_last = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE:  if (bus.in_valid)  w_fsm_nxt = ST_ROUND;
      ST_ROUND: if (w_cnt_last)    w_fsm_nxt = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_fsm_nxt = ST_IDLE;
      default:                     w_fsm_nxt = ST_IDLE;
    endcase
  end

  // Round 0 (initial AddRoundKey) is folded into the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk <= '0;
      r_key <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_blk <= bus.in_data ^ bus.in_key;
      r_key <= bus.in_key;
      r_cnt <= c_cnt_one;
    end else if (w_step) begin
      r_blk <= bus.rnd_out;
      r_key <= bus.rnd_keyout;
      if (!w_cnt_last) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign bus.in_ready  = (r_fsm == ST_IDLE);
  assign bus.rnd_rc    = w_step ? RCW'(r_cnt - c_cnt_one) : '0;
  assign bus.rnd_last  = w_step && w_cnt_last;
  assign bus.rnd_data  = r_blk;
  assign bus.rnd_key   = r_key;
  assign bus.out_valid = (r_fsm == ST_DONE);
  assign bus.out_data  = (r_fsm == ST_DONE) ? r_blk : '0;

endmodule : aes_round_ctrl

`default_nettype wire
